gcd_feeder: RTL and testbench

Upstream sequencer for the GCD datapath/controller pair. Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. Serialises each pair onto the core's single `data_in` bus with the `start` protocol, waits for `done`, and returns the captured result with its operands over a valid/ready output port. Zero operands bypass the core, which would never terminate on them.

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_feeder_if.sv | 34 +++
 rtl/gcd_pair_fifo.sv | 61 ++++++
 rtl/gcd_feeder.sv | 179 +++++++++++++++++
 tb/tb_gcd_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD feeder and its FIFO.
package gcd_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        IDLE,
        START,
        LDA,
        LDB,
        WAIT,
        EMIT
    } state_t;

endpackage

// File: rtl/gcd_feeder_if.sv
// Operand input, GCD core and result output bundle; master is the feeder side.
interface gcd_feeder_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_data;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic             busy;

    modport master (
        input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        output in_ready, gcd_start, gcd_data, out_valid, out_a, out_b, out_gcd, out_err, busy
    );

    modport slave (
        output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        input  in_ready, gcd_start, gcd_data, out_valid, out_a, out_b, out_gcd, out_err, busy
    );

endinterface

// File: rtl/gcd_pair_fifo.sv
// Operand-pair FIFO with registered storage; read data is the head entry, zero latency.
// Push while full is accepted only together with a pop in the same cycle.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int DW    = 2 * DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_feeder.sv
// Sequences buffered operand pairs through the GCD core; result 2 cycles after pop (bypass) or after done.
// Holds the result until accepted, no pop while held. Optional watchdog: GCD_FEEDER_TIMEOUT_EN.
module gcd_feeder
    import gcd_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    gcd_feeder_if.master  bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $error("gcd_feeder: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [PW-1:0]    head;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             head_zero;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic [WIDTH-1:0] res_q;
    logic             out_vld_q;
    logic [WIDTH-1:0] out_a_q;
    logic [WIDTH-1:0] out_b_q;
    logic [WIDTH-1:0] out_gcd_q;
    logic             wd_fire;

    assign bus.in_ready = ~full;
    assign push         = bus.in_valid & ~full;
    assign head_a       = head[PW-1:WIDTH];
    assign head_b       = head[WIDTH-1:0];
    assign head_zero    = (head_a == '0) | (head_b == '0);

    gcd_pair_fifo #(
        .DW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({bus.in_a, bus.in_b}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = head_zero ? EMIT : START;
            START:   state_nxt = LDA;
            LDA:     state_nxt = LDB;
            LDB:     state_nxt = WAIT;
            WAIT:    if (bus.gcd_done || wd_fire) state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done is only trusted in WAIT; earlier it may be the previous run's level.
    always_comb begin
        pop           = 1'b0;
        bus.gcd_start = 1'b0;
        bus.gcd_data  = '0;
        case (state)
            IDLE:      pop = ~empty & ~out_vld_q;
            START: begin
                bus.gcd_start = 1'b1;
                bus.gcd_data  = cur_a;
            end
            LDA:       bus.gcd_data = cur_a;
            LDB, WAIT: bus.gcd_data = cur_b;
            default:   ;
        endcase
    end

`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] wd_cnt;
    logic          err_q;
    logic          out_err_q;

    // Fires in the WAIT cycle that brings the count up to TIMEOUT.
    assign wd_fire     = (state == WAIT) & ~bus.gcd_done & (wd_cnt == WD_LAST);
    assign bus.out_err = out_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= '0;
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            if (state == LDB) begin
                wd_cnt <= '0;
            end else if (state == WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (pop) begin
                err_q <= 1'b0;
            end else if (wd_fire) begin
                err_q <= 1'b1;
            end
            if (state == EMIT) begin
                out_err_q <= err_q;
            end
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign bus.out_err = 1'b0;
`endif

    // Bypass result a|b is preloaded on pop; WAIT overwrites it for real core runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_a     <= '0;
            cur_b     <= '0;
            res_q     <= '0;
            out_vld_q <= 1'b0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_gcd_q <= '0;
        end else begin
            if (pop) begin
                cur_a <= head_a;
                cur_b <= head_b;
                res_q <= head_a | head_b;
            end
            if (state == WAIT) begin
                if (bus.gcd_done) begin
                    res_q <= bus.gcd_result;
                end else if (wd_fire) begin
                    res_q <= '0;
                end
            end
            if (state == EMIT) begin
                out_vld_q <= 1'b1;
                out_a_q   <= cur_a;
                out_b_q   <= cur_b;
                out_gcd_q <= res_q;
            end else if (out_vld_q && bus.out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_vld_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_gcd   = out_gcd_q;
    assign bus.busy      = (state != IDLE) | (count != '0);

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder with a behavioural subtract-loop GCD core attached.
module tb_gcd_feeder;

    localparam int W = 16;
`ifdef GCD_FEEDER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    gcd_feeder_if #(.WIDTH(W)) bus ();

    gcd_feeder #(
        .WIDTH   (W),
        .DEPTH   (4),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core: start re-arms; loads A then B on the next two edges; done is a held level.
    logic [1:0]   cst = 2'd0;
    logic [W-1:0] ca = '0;
    logic [W-1:0] cb = '0;
    logic         core_done = 1'b0;
    logic         stuck = 1'b0;

    assign bus.gcd_done   = core_done & ~stuck;
    assign bus.gcd_result = ca;

    always @(posedge clk) begin
        if (bus.gcd_start) begin
            cst       <= 2'd1;
            core_done <= 1'b0;
        end else begin
            case (cst)
                2'd1: begin ca <= bus.gcd_data; cst <= 2'd2; end
                2'd2: begin cb <= bus.gcd_data; cst <= 2'd3; end
                2'd3: begin
                    if (ca == cb) begin
                        core_done <= 1'b1;
                        cst       <= 2'd0;
                    end else if (ca > cb) begin
                        ca <= ca - cb;
                    end else begin
                        cb <= cb - ca;
                    end
                end
                default: ;
            endcase
        end
    end

    int           start_cnt = 0;
    logic [W-1:0] seq [3];
    int           ph = 0;

    always @(negedge clk) begin
        if (bus.gcd_start) begin
            start_cnt = start_cnt + 1;
            seq[0] = bus.gcd_data;
            ph = 1;
        end else if (ph == 1) begin
            seq[1] = bus.gcd_data;
            ph = 2;
        end else if (ph == 2) begin
            seq[2] = bus.gcd_data;
            ph = 0;
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        while (!bus.in_ready) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                $display("FAIL push_timeout: in_ready stayed 0 for a=%0d b=%0d, required 1", a, b);
                $fatal(1, "push timeout");
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.out_valid) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                $display("FAIL out_timeout: out_valid stayed 0, required 1");
                $fatal(1, "output timeout");
            end
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.gcd_start, bus.busy, bus.out_err} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 10000", {bus.in_ready, bus.out_valid, bus.gcd_start, bus.busy, bus.out_err});
        end
        vectors++;
        if ({bus.gcd_data, bus.out_a, bus.out_b, bus.out_gcd} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {bus.gcd_data, bus.out_a, bus.out_b, bus.out_gcd});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL after_reset_idle: got %b want 100", {bus.in_ready, bus.busy, bus.out_valid});
        end
    endtask

    task automatic test_core();
        int base = start_cnt;
        push(16'd143, 16'd78);
        @(negedge clk);
        vectors++;
        if ({bus.gcd_start, bus.gcd_data} !== {1'b1, 16'd143}) begin
            miscompares++;
            $display("FAIL core_start_cycle: got start=%b data=%0d want start=1 data=143", bus.gcd_start, bus.gcd_data);
        end
        wait_out();
        vectors++;
        if ({bus.out_a, bus.out_b, bus.out_gcd, bus.out_err} !== {16'd143, 16'd78, 16'd13, 1'b0}) begin
            miscompares++;
            $display("FAIL core_result: got a=%0d b=%0d gcd=%0d err=%b want 143 78 13 0", bus.out_a, bus.out_b, bus.out_gcd, bus.out_err);
        end
        vectors++;
        if (start_cnt - base !== 1) begin
            miscompares++;
            $display("FAIL core_start_count: got %0d want 1", start_cnt - base);
        end
        vectors++;
        if ({seq[0], seq[1], seq[2]} !== {16'd143, 16'd143, 16'd78}) begin
            miscompares++;
            $display("FAIL core_data_seq: got %0d,%0d,%0d want 143,143,78", seq[0], seq[1], seq[2]);
        end
        ack();
    endtask

    task automatic test_zero_bypass();
        int base = start_cnt;
        logic [W-1:0] zb [2] = '{16'd25, 16'd0};
        for (int i = 0; i < 2; i++) begin
            push(16'd0, zb[i]);
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_early_%0d: out_valid got %b want 0 one cycle after pop", i, bus.out_valid);
            end
            @(negedge clk);
            vectors++;
            if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_gcd} !== {1'b1, 16'd0, zb[i], zb[i]}) begin
                miscompares++;
                $display("FAIL zero_result_%0d: got vld=%b a=%0d b=%0d gcd=%0d want 1 0 %0d %0d", i, bus.out_valid, bus.out_a, bus.out_b, bus.out_gcd, zb[i], zb[i]);
            end
            ack();
        end
        vectors++;
        if (start_cnt !== base) begin
            miscompares++;
            $display("FAIL zero_no_start: start pulses got %0d want 0", start_cnt - base);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [5] = '{16'd48, 16'd17, 16'd100, 16'd81, 16'd35};
        logic [W-1:0] vb [5] = '{16'd18, 16'd5, 16'd75, 16'd27, 16'd64};
        logic [W-1:0] vg [5] = '{16'd6, 16'd1, 16'd25, 16'd27, 16'd1};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(va[i], vb[i]);
        repeat (60) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.out_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_full: got in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            wait_out();
            vectors++;
            if ({bus.out_a, bus.out_b, bus.out_gcd} !== {va[i], vb[i], vg[i]}) begin
                miscompares++;
                $display("FAIL b2b_result_%0d: got %0d %0d %0d want %0d %0d %0d", i, bus.out_a, bus.out_b, bus.out_gcd, va[i], vb[i], vg[i]);
            end
            ack();
            if (i == 0) begin
                @(negedge clk);
                vectors++;
                if (bus.in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready_return: in_ready got %b want 1", bus.in_ready);
                end
            end
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drained: busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        push(16'd1000, 16'd1);
        push(16'd9, 16'd6);
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.gcd_start, bus.gcd_data} !== {1'b1, 1'b0, 16'd1}) begin
            miscompares++;
            $display("FAIL mid_wait_state: got busy=%b start=%b data=%0d want 1 0 1", bus.busy, bus.gcd_start, bus.gcd_data);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.in_ready, bus.busy, bus.out_valid, bus.gcd_start, bus.out_err, bus.gcd_data, bus.out_gcd} !== {1'b1, 4'b0000, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got rdy=%b busy=%b vld=%b start=%b err=%b data=%0d gcd=%0d want 1 0 0 0 0 0 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.gcd_start, bus.out_err, bus.gcd_data, bus.out_gcd);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(16'd21, 16'd14);
        wait_out();
        vectors++;
        if ({bus.out_a, bus.out_b, bus.out_gcd} !== {16'd21, 16'd14, 16'd7}) begin
            miscompares++;
            $display("FAIL mid_fresh_pair: got %0d %0d %0d want 21 14 7", bus.out_a, bus.out_b, bus.out_gcd);
        end
        ack();
        repeat (30) @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_fifo_flushed: got vld=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_stuck_done();
        stuck = 1'b1;
        push(16'd12, 16'd8);
`ifdef GCD_FEEDER_TIMEOUT_EN
        begin : wd_on
            int n;
            n = 0;
            while (!bus.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (n !== 13) begin
                miscompares++;
                $display("FAIL wd_latency: out_valid after %0d cycles want 13", n);
            end
            vectors++;
            if ({bus.out_valid, bus.out_err, bus.out_gcd, bus.out_a, bus.out_b} !== {2'b11, 16'd0, 16'd12, 16'd8}) begin
                miscompares++;
                $display("FAIL wd_abort: got vld=%b err=%b gcd=%0d a=%0d b=%0d want 1 1 0 12 8", bus.out_valid, bus.out_err, bus.out_gcd, bus.out_a, bus.out_b);
            end
            ack();
            stuck = 1'b0;
            push(16'd21, 16'd14);
            wait_out();
            vectors++;
            if ({bus.out_err, bus.out_gcd} !== {1'b0, 16'd7}) begin
                miscompares++;
                $display("FAIL wd_err_clears: got err=%b gcd=%0d want 0 7", bus.out_err, bus.out_gcd);
            end
            ack();
        end
`else
        begin : wd_off
            bit seen;
            seen = 1'b0;
            repeat (2000) begin
                @(negedge clk);
                if (bus.out_valid) seen = 1'b1;
            end
            vectors++;
            if (seen !== 1'b0) begin
                miscompares++;
                $display("FAIL stuck_no_output: out_valid seen %b want 0", seen);
            end
            vectors++;
            if ({bus.busy, bus.gcd_data, bus.out_err} !== {1'b1, 16'd8, 1'b0}) begin
                miscompares++;
                $display("FAIL stuck_in_wait: got busy=%b data=%0d err=%b want 1 8 0", bus.busy, bus.gcd_data, bus.out_err);
            end
            rst = 1'b1;
            stuck = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
        end
`endif
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_core();
        test_zero_bypass();
        test_back_to_back();
        test_reset_mid_run();
        test_stuck_done();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
